unpacked_array_serializer: RTL and testbench
============================================

# unpacked_array_serializer

- Drains an M-entry unpacked array of W-bit words as a word-serial stream with a valid/ready handshake.
- Transmit-side counterpart of the capture blocks that fan a packed input into unpacked array registers: this block unloads such an array, one word per accepted beat, toward a narrower downstream link.
- Internal state (buffer, counter, FSM) is triplicated by default; the `d_*` and `q_*` ports are not triplicated.

## Interface
Parameters:
- `M`, default 4: number of array entries; M ≥ 1.
- `W`, default 8: word width in bits; W ≥ 1.
- `IW`, default max(1, $clog2(M)): width of the index output. Derived; never overridden.

Ports:
- `clock`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `d_valid`, input, 1: source offers an array on `d`.
- `d_ready`, output, 1: block can capture an array.
- `d`, input, W × [0:M-1] (unpacked): array to serialize; sampled only on load.
- `flush`, input, 1: synchronous abort of the array in flight.
- `q_valid`, output, 1: `q` holds a valid word.
- `q_ready`, input, 1: sink accepts the word.
- `q`, output, W: current word.
- `q_idx`, output, IW: array index of the current word.
- `q_last`, output, 1: current word is entry M-1.

## Operation
FSM has two states, IDLE and SEND. All outputs are registered.

IDLE:
- `d_ready` = 1, `q_valid` = 0.
- Load occurs when `d_valid` = 1.
- On load: capture all M entries of `d` into buffer `buf[0:M-1]`, clear counter `idx` to 0, go to SEND.

SEND:
- `q_valid` = 1, `q` = `buf[idx]`, `q_idx` = `idx`, `q_last` = (`idx` == M-1), `d_ready` = 0.
- A beat is accepted when `q_valid` and `q_ready` are both 1.
- On an accepted beat with `idx` < M-1: `idx` increments by 1.
- On an accepted beat with `idx` == M-1: go to IDLE, and `idx` wraps to 0.
- With `q_ready` = 0, `q`, `q_idx`, `q_last` and `q_valid` hold stable. Once asserted, `q_valid` never drops without an accepted beat, except on flush or reset.

Flush:
- In SEND: go to IDLE next cycle and discard the remaining words. Buffer contents are not cleared.
- Flush in the same cycle as an accepted beat: the beat counts as delivered; still go to IDLE.
- Flush in IDLE: no effect. A simultaneous `d_valid` load is still performed.

Reset:
- `reset` overrides flush and all handshakes.
- In any state (including mid-array) the next cycle gives: IDLE, `idx` = 0, `buf` all zeros.
- Output values after reset: `d_ready` = 1, `q_valid` = 0, `q` = 0, `q_idx` = 0, `q_last` = (M == 1 ? 1 : 0).

M = 1:
- `q_last` is constantly 1 in SEND.
- Each array is a single beat.

`d` is ignored outside the load cycle. Changes to `d` while in SEND do not affect `q`.

## Timing
- Load latency: load accepted at edge t → `q_valid` = 1 with `buf[0]` from cycle t+1.
- Throughput in SEND with `q_ready` held high: one word per cycle. An array takes M cycles.
- Turnaround: last beat accepted at edge t → `d_ready` = 1 in cycle t+1, so the next load can occur at edge t+1. The first word of the next array appears in t+2, giving one bubble cycle per array.
- Flush asserted at edge t → `q_valid` = 0 and `d_ready` = 1 in t+1.
- `reset` asserted at edge t → every output at its reset value in t+1.
- No combinational path from any input to any output.

## Test plan
- Basic drain (M=4, W=8): load d = {0x11, 0x22, 0x33, 0x44}, `q_ready` = 1 → `q` = 0x11, 0x22, 0x33, 0x44 on consecutive cycles; `q_idx` = 0..3; `q_last` only with 0x44; `d_ready` = 1 in the following cycle.
- Backpressure: hold `q_ready` = 0 for 3 cycles during idx=1 → `q` stays 0x22 with `q_idx` = 1 and `q_valid` = 1 for those 3 cycles; the sequence resumes without loss or duplication.
- Back-to-back arrays with `d_valid` held high: second array {0xA0, 0xA1, 0xA2, 0xA3} → exactly one idle cycle between 0x44 and 0xA0; `d` changes during SEND do not alter the first array's words.
- Flush at idx=2 coincident with an accepted beat → 0x33 delivered, 0x44 never presented; IDLE next cycle; a new load sends from idx 0.
- Reset at idx=1 while stalled → next cycle `q_valid` = 0, `d_ready` = 1, `q` = 0, `q_idx` = 0. Reset and flush asserted together → reset outcome.
- M=1, W=8: load {0x5A} → single beat, `q` = 0x5A with `q_last` = 1 and `q_idx` = 0; back in IDLE after acceptance.

Source files
------------

// File: rtl/unpacked_array_serializer.sv
// Unloads an M-entry unpacked array of W-bit words as a valid/ready word stream.
// Buffer, index and FSM state are held in three voted copies; outputs are registered.
module unpacked_array_serializer #(
  parameter int unsigned M  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned IW = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          d_valid,
  output logic          d_ready,
  input  logic [W-1:0]  d [0:M-1],
  input  logic          flush,
  output logic          q_valid,
  input  logic          q_ready,
  output logic [W-1:0]  q,
  output logic [IW-1:0] q_idx,
  output logic          q_last
);

  typedef enum logic {StIdle, StSend} state_e;

  localparam int unsigned   NumCopies = 3;
  localparam logic [IW-1:0] LastIdx   = IW'(M - 1);

  // Triplicated state
  state_e        state_q [NumCopies];
  logic [IW-1:0] idx_q   [NumCopies];
  logic [W-1:0]  buf_q   [NumCopies][M];

  // Voted view and next state (shared by all copies, so a single upset is scrubbed)
  state_e        state_v, state_d;
  logic [IW-1:0] idx_v, idx_d;
  logic [W-1:0]  buf_v [M];
  logic [W-1:0]  buf_d [M];

  // Registered outputs
  logic          d_ready_q, d_ready_d;
  logic          q_valid_q, q_valid_d;
  logic [W-1:0]  q_q, q_d;
  logic [IW-1:0] q_idx_q, q_idx_d;
  logic          q_last_q, q_last_d;

  logic accept;

  function automatic logic [W-1:0] vote_word(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [IW-1:0] vote_idx(input logic [IW-1:0] a, input logic [IW-1:0] b,
                                             input logic [IW-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_comb begin
    state_v = state_e'((state_q[0] & state_q[1]) | (state_q[0] & state_q[2]) |
                       (state_q[1] & state_q[2]));
    idx_v   = vote_idx(idx_q[0], idx_q[1], idx_q[2]);
    for (int i = 0; i < int'(M); i++) begin
      buf_v[i] = vote_word(buf_q[0][i], buf_q[1][i], buf_q[2][i]);
    end
  end

  always_comb begin
    state_d = state_v;
    idx_d   = idx_v;
    buf_d   = buf_v;
    accept  = (state_v == StSend) && q_ready;
    unique case (state_v)
      StIdle: begin
        if (d_valid) begin
          state_d = StSend;
          idx_d   = '0;
          buf_d   = d;
        end
      end
      StSend: begin
        if (accept) begin
          if (idx_v == LastIdx) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_v + IW'(1);
          end
        end
        // A beat accepted alongside flush still counts; the rest is dropped.
        if (flush) begin
          state_d = StIdle;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase

    d_ready_d = (state_d == StIdle);
    q_valid_d = (state_d == StSend);
    q_d       = buf_d[idx_d];
    q_idx_d   = idx_d;
    q_last_d  = (idx_d == LastIdx);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < int'(NumCopies); c++) begin
        state_q[c] <= StIdle;
        idx_q[c]   <= '0;
        for (int i = 0; i < int'(M); i++) begin
          buf_q[c][i] <= '0;
        end
      end
      d_ready_q <= 1'b1;
      q_valid_q <= 1'b0;
      q_q       <= '0;
      q_idx_q   <= '0;
      q_last_q  <= (M == 1);
    end else begin
      for (int c = 0; c < int'(NumCopies); c++) begin
        state_q[c] <= state_d;
        idx_q[c]   <= idx_d;
        buf_q[c]   <= buf_d;
      end
      d_ready_q <= d_ready_d;
      q_valid_q <= q_valid_d;
      q_q       <= q_d;
      q_idx_q   <= q_idx_d;
      q_last_q  <= q_last_d;
    end
  end

  assign d_ready = d_ready_q;
  assign q_valid = q_valid_q;
  assign q       = q_q;
  assign q_idx   = q_idx_q;
  assign q_last  = q_last_q;

endmodule

// File: tb/tb_unpacked_array_serializer.sv
// Scoreboard bench: directed loads push expected beats; monitors pop on each accepted beat.
module tb_unpacked_array_serializer;

  typedef struct {
    logic [7:0] w;
    logic [1:0] i;
    logic       l;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // M=4 instance
  logic       d_valid4, d_ready4, flush4, q_valid4, q_ready4, q_last4;
  logic [7:0] d4 [0:3];
  logic [7:0] q4;
  logic [1:0] q_idx4;

  // M=1 instance
  logic       d_valid1, d_ready1, flush1, q_valid1, q_ready1, q_last1;
  logic [7:0] d1 [0:0];
  logic [7:0] q1;
  logic [0:0] q_idx1;

  unpacked_array_serializer #(.M(4), .W(8)) dut4 (
    .clock(clk), .reset(reset), .d_valid(d_valid4), .d_ready(d_ready4), .d(d4),
    .flush(flush4), .q_valid(q_valid4), .q_ready(q_ready4), .q(q4), .q_idx(q_idx4),
    .q_last(q_last4)
  );

  unpacked_array_serializer #(.M(1), .W(8)) dut1 (
    .clock(clk), .reset(reset), .d_valid(d_valid1), .d_ready(d_ready1), .d(d1),
    .flush(flush1), .q_valid(q_valid1), .q_ready(q_ready1), .q(q1), .q_idx(q_idx1),
    .q_last(q_last1)
  );

  int n_cmp = 0;
  int n_err = 0;
  exp_t exp4_q[$];
  exp_t exp1_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] e, input int n);
    logic [7:0] v [4];
    v = '{a, b, c, e};
    for (int k = 0; k < n; k++) exp4_q.push_back('{w: v[k], i: 2'(k), l: (k == 3)});
  endtask

  task automatic load4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] e);
    d4 = '{a, b, c, e};
    d_valid4 = 1'b1;
    step();
    d_valid4 = 1'b0;
  endtask

  // Monitors: a beat is accepted at the coming edge when valid and ready are both high.
  always @(negedge clk) begin
    if (!reset && q_valid4 && q_ready4) begin
      if (exp4_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL m4_unexpected_beat: got q=0x%0h idx=%0d, expected no beat", q4, q_idx4);
      end else begin
        exp_t e;
        e = exp4_q.pop_front();
        chk("m4_q", 32'(q4), 32'(e.w));
        chk("m4_idx", 32'(q_idx4), 32'(e.i));
        chk("m4_last", 32'(q_last4), 32'(e.l));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && q_valid1 && q_ready1) begin
      if (exp1_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL m1_unexpected_beat: got q=0x%0h, expected no beat", q1);
      end else begin
        exp_t e;
        e = exp1_q.pop_front();
        chk("m1_q", 32'(q1), 32'(e.w));
        chk("m1_idx", 32'(q_idx1), 32'(e.i));
        chk("m1_last", 32'(q_last1), 32'(e.l));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    d_valid4 = 1'b0; flush4 = 1'b0; q_ready4 = 1'b0; d4 = '{8'h00, 8'h00, 8'h00, 8'h00};
    d_valid1 = 1'b0; flush1 = 1'b0; q_ready1 = 1'b0; d1 = '{8'h00};
    step(); step();
    chk("rst_d_ready", 32'(d_ready4), 32'd1);
    chk("rst_q_valid", 32'(q_valid4), 32'd0);
    chk("rst_q", 32'(q4), 32'd0);
    chk("rst_q_idx", 32'(q_idx4), 32'd0);
    chk("rst_q_last", 32'(q_last4), 32'd0);
    chk("rst1_q_last", 32'(q_last1), 32'd1);
    reset = 1'b0;
    step();

    // Basic drain
    q_ready4 = 1'b1;
    push4(8'h11, 8'h22, 8'h33, 8'h44, 4);
    load4(8'h11, 8'h22, 8'h33, 8'h44);
    d4 = '{8'hEE, 8'hEE, 8'hEE, 8'hEE};
    chk("basic_d_ready_send", 32'(d_ready4), 32'd0);
    repeat (4) step();
    chk("basic_d_ready_after", 32'(d_ready4), 32'd1);
    chk("basic_q_valid_after", 32'(q_valid4), 32'd0);

    // Backpressure at idx 1
    push4(8'h11, 8'h22, 8'h33, 8'h44, 4);
    load4(8'h11, 8'h22, 8'h33, 8'h44);
    step();
    q_ready4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_q", 32'(q4), 32'h22);
      chk("bp_idx", 32'(q_idx4), 32'd1);
      chk("bp_valid", 32'(q_valid4), 32'd1);
      step();
    end
    q_ready4 = 1'b1;
    repeat (3) step();
    chk("bp_idle", 32'(d_ready4), 32'd1);

    // Back-to-back with d_valid held high; d changes during SEND
    push4(8'h11, 8'h22, 8'h33, 8'h44, 4);
    push4(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4);
    d4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    d_valid4 = 1'b1;
    step();
    d4 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    repeat (4) step();
    chk("b2b_bubble_valid", 32'(q_valid4), 32'd0);
    chk("b2b_bubble_ready", 32'(d_ready4), 32'd1);
    step();
    d_valid4 = 1'b0;
    chk("b2b_first_word", 32'(q4), 32'hA0);
    repeat (4) step();
    chk("b2b_idle", 32'(d_ready4), 32'd1);

    // Flush at idx 2 coincident with an accepted beat
    push4(8'h11, 8'h22, 8'h33, 8'h44, 3);
    load4(8'h11, 8'h22, 8'h33, 8'h44);
    step(); step();
    flush4 = 1'b1;
    step();
    flush4 = 1'b0;
    chk("flush_q_valid", 32'(q_valid4), 32'd0);
    chk("flush_d_ready", 32'(d_ready4), 32'd1);
    push4(8'h55, 8'h66, 8'h77, 8'h88, 4);
    load4(8'h55, 8'h66, 8'h77, 8'h88);
    chk("flush_reload_idx", 32'(q_idx4), 32'd0);
    repeat (4) step();

    // Reset at idx 1 while stalled
    push4(8'h11, 8'h22, 8'h33, 8'h44, 1);
    load4(8'h11, 8'h22, 8'h33, 8'h44);
    step();
    q_ready4 = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_q_valid", 32'(q_valid4), 32'd0);
    chk("rst_mid_d_ready", 32'(d_ready4), 32'd1);
    chk("rst_mid_q", 32'(q4), 32'd0);
    chk("rst_mid_q_idx", 32'(q_idx4), 32'd0);
    q_ready4 = 1'b1;

    // Reset and flush together
    push4(8'h11, 8'h22, 8'h33, 8'h44, 1);
    load4(8'h11, 8'h22, 8'h33, 8'h44);
    step();
    q_ready4 = 1'b0;
    reset = 1'b1;
    flush4 = 1'b1;
    step();
    reset = 1'b0;
    flush4 = 1'b0;
    chk("rstfl_q_valid", 32'(q_valid4), 32'd0);
    chk("rstfl_d_ready", 32'(d_ready4), 32'd1);
    chk("rstfl_q", 32'(q4), 32'd0);
    chk("rstfl_q_idx", 32'(q_idx4), 32'd0);
    q_ready4 = 1'b1;

    // M=1 single beat
    exp1_q.push_back('{w: 8'h5A, i: 2'd0, l: 1'b1});
    d1 = '{8'h5A};
    d_valid1 = 1'b1;
    q_ready1 = 1'b1;
    step();
    d_valid1 = 1'b0;
    d1 = '{8'hFF};
    chk("m1_valid", 32'(q_valid1), 32'd1);
    step();
    chk("m1_idle_ready", 32'(d_ready1), 32'd1);
    chk("m1_idle_valid", 32'(q_valid1), 32'd0);

    step(); step();
    chk("m4_queue_empty", 32'(exp4_q.size()), 32'd0);
    chk("m1_queue_empty", 32'(exp1_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
